// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the MIPS32 multiply/divide unit.
//   - op encodings carried on the 3-bit op bus (6..7 are reserved no-ops)
//   - FSM state encodings
//   - iteration count for the radix-2 multiply/divide loop
//   - LO value written on divide by zero
package mdu_pkg;

    localparam int unsigned MDU_ITER    = 32;
    localparam logic [31:0] MDU_DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        MDU_OP_MULT  = 3'd0,
        MDU_OP_MULTU = 3'd1,
        MDU_OP_DIV   = 3'd2,
        MDU_OP_DIVU  = 3'd3,
        MDU_OP_MTHI  = 3'd4,
        MDU_OP_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/result bundle between the EX stage and the
// multiply/divide unit.
//   master (EX control): drives start, op, a, b; sees busy and HI/LO writes
//   slave  (mult_div_unit): the reverse
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             hi_wen;
    logic             lo_wen;
    logic [WIDTH-1:0] hi_data;
    logic [WIDTH-1:0] lo_data;

    modport master (
        output start, op, a, b,
        input  busy, hi_wen, lo_wen, hi_data, lo_data
    );

    modport slave (
        input  start, op, a, b,
        output busy, hi_wen, lo_wen, hi_data, lo_data
    );
endinterface

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division step.
//   rem_in       current partial remainder (always < divisor)
//   dividend_bit next dividend bit shifted into the remainder
//   divisor      divisor magnitude
//   rem_out      next partial remainder
//   q_bit        quotient bit produced by this step
module mdu_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    always_comb begin
        shifted = {rem_in, dividend_bit};
        q_bit   = (shifted >= {1'b0, divisor});
        // When the subtraction is taken the true difference is below
        // 2^WIDTH, so the modulo-2^WIDTH difference of the low bits is exact.
        diff    = shifted[WIDTH-1:0] - divisor;
        rem_out = q_bit ? diff : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit feeding the
// HI/LO registers.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mult_div_unit_if.slave (start/op/a/b in; busy and registered
//              HI/LO write pulses and data out)
// Build option: define MDU_FAST_MULT_EN to compute MULT/MULTU in a single
// CALC cycle with a native multiplier; divide stays iterative.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    mult_div_unit_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(MDU_ITER);

    mdu_state_e         state;
    logic [CNT_W-1:0]   cnt;
    // Shared accumulator: multiply holds {partial product, multiplier};
    // divide holds {partial remainder, remaining dividend/quotient bits}.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd_q;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   a_q;
    logic               is_mul_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic               div0_q;

    logic               busy_q;
    logic               hi_wen_q;
    logic               lo_wen_q;
    logic [WIDTH-1:0]   hi_data_q;
    logic [WIDTH-1:0]   lo_data_q;

    logic               in_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   rem_out;
    logic               q_bit;
    logic               last_step;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

`ifndef MDU_FAST_MULT_EN
    logic [WIDTH:0]     add_term;
    logic [WIDTH:0]     mul_sum;
`endif

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in       (acc[2*WIDTH-1:WIDTH]),
        .dividend_bit (acc[WIDTH-1]),
        .divisor      (opnd_q),
        .rem_out      (rem_out),
        .q_bit        (q_bit)
    );

    // Operand magnitudes for the incoming request.
    always_comb begin
        in_signed = op_is_signed(bus.op);
        a_neg     = in_signed & bus.a[WIDTH-1];
        b_neg     = in_signed & bus.b[WIDTH-1];
        a_mag     = a_neg ? -bus.a : bus.a;
        b_mag     = b_neg ? -bus.b : bus.b;
    end

    // One CALC step and the sign-corrected results it would produce.
    always_comb begin
`ifdef MDU_FAST_MULT_EN
        mul_next  = (2*WIDTH)'(opnd_q) * (2*WIDTH)'(acc[WIDTH-1:0]);
        last_step = (cnt == '0) || is_mul_q;
`else
        add_term  = acc[0] ? {1'b0, opnd_q} : '0;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + add_term;
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        last_step = (cnt == '0);
`endif
        div_next  = {rem_out, acc[WIDTH-2:0], q_bit};
        step_next = is_mul_q ? mul_next : div_next;
        prod      = neg_res_q ? -step_next : step_next;

        if (is_mul_q) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (div0_q) begin
            res_hi = a_q;
            res_lo = WIDTH'(MDU_DIV0_LO);
        end else begin
            res_hi = neg_rem_q ? -step_next[2*WIDTH-1:WIDTH] : step_next[2*WIDTH-1:WIDTH];
            res_lo = neg_res_q ? -step_next[WIDTH-1:0]       : step_next[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            acc       <= '0;
            opnd_q    <= '0;
            a_q       <= '0;
            is_mul_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            busy_q    <= 1'b0;
            hi_wen_q  <= 1'b0;
            lo_wen_q  <= 1'b0;
            hi_data_q <= '0;
            lo_data_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    hi_wen_q <= 1'b0;
                    lo_wen_q <= 1'b0;
                    if (bus.start) begin
                        case (bus.op)
                            MDU_OP_MTHI: begin
                                hi_data_q <= bus.a;
                                hi_wen_q  <= 1'b1;
                                busy_q    <= 1'b1;
                                state     <= ST_DONE;
                            end
                            MDU_OP_MTLO: begin
                                lo_data_q <= bus.a;
                                lo_wen_q  <= 1'b1;
                                busy_q    <= 1'b1;
                                state     <= ST_DONE;
                            end
                            MDU_OP_MULT, MDU_OP_MULTU: begin
                                acc       <= {{WIDTH{1'b0}}, b_mag};
                                opnd_q    <= a_mag;
                                is_mul_q  <= 1'b1;
                                neg_res_q <= a_neg ^ b_neg;
                                neg_rem_q <= 1'b0;
                                div0_q    <= 1'b0;
                                cnt       <= CNT_W'(MDU_ITER - 1);
                                busy_q    <= 1'b1;
                                state     <= ST_CALC;
                            end
                            MDU_OP_DIV, MDU_OP_DIVU: begin
                                acc       <= {{WIDTH{1'b0}}, a_mag};
                                opnd_q    <= b_mag;
                                a_q       <= bus.a;
                                is_mul_q  <= 1'b0;
                                neg_res_q <= a_neg ^ b_neg;
                                neg_rem_q <= a_neg;
                                div0_q    <= (bus.b == '0);
                                cnt       <= CNT_W'(MDU_ITER - 1);
                                busy_q    <= 1'b1;
                                state     <= ST_CALC;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_CALC: begin
                    acc <= step_next;
                    cnt <= cnt - 1'b1;
                    if (last_step) begin
                        hi_data_q <= res_hi;
                        lo_data_q <= res_lo;
                        hi_wen_q  <= 1'b1;
                        lo_wen_q  <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    hi_wen_q <= 1'b0;
                    lo_wen_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.hi_wen  = hi_wen_q;
    assign bus.lo_wen  = lo_wen_q;
    assign bus.hi_data = hi_data_q;
    assign bus.lo_data = lo_data_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: self-checking bench for mult_div_unit. Directed cases
// plus randomized ops compared against a plain-arithmetic reference model.
// Honours MDU_FAST_MULT_EN for the expected multiply latency.
module tb_mult_div_unit;
    import mdu_pkg::*;

`ifdef MDU_FAST_MULT_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(32)) bus ();
    mult_div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: HI/LO writes from the architectural definition of each op.
    function automatic void ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo,
                                    output logic hw, output logic lw, output int lat);
        longint sa, sb, sp;
        logic [63:0] up;
        hi = '0; lo = '0; hw = 1'b1; lw = 1'b1; lat = 33;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin sp = sa * sb; {hi, lo} = sp; lat = MUL_LAT; end
            3'd1: begin up = {32'b0, a} * {32'b0, b}; {hi, lo} = up; lat = MUL_LAT; end
            3'd2: if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
                  else begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
            3'd3: if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
                  else begin lo = a / b; hi = a % b; end
            3'd4: begin hi = a; lw = 1'b0; lat = 1; end
            3'd5: begin lo = a; hw = 1'b0; lat = 1; end
            default: begin hw = 1'b0; lw = 1'b0; lat = 0; end
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, input string tag);
        logic [31:0] ehi, elo;
        logic ehw, elw;
        int elat, done_cyc, busy_low;
        ref_mdu(op, a, b, ehi, elo, ehw, elw, elat);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
        if (elat == 0) begin
            busy_low = 0;
            repeat (3) begin
                @(negedge clk);
                if (bus.busy || bus.hi_wen || bus.lo_wen) busy_low++;
            end
            check_eq({tag, "_reserved_idle"}, 64'(busy_low), 64'd0);
            return;
        end
        done_cyc = 0;
        busy_low = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (bus.hi_wen || bus.lo_wen) begin
                done_cyc = cyc;
                break;
            end
            if (!bus.busy) busy_low++;
            if (disturb && cyc == 5) begin
                bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hDEAD_BEEF; bus.b = 32'd0;
            end
            if (disturb && cyc == 6) bus.start = 1'b0;
        end
        check_eq({tag, "_latency"}, 64'(done_cyc), 64'(elat));
        check_eq({tag, "_busy_calc"}, 64'(busy_low), 64'd0);
        check_eq({tag, "_busy_done"}, 64'(bus.busy), 64'd1);
        check_eq({tag, "_hi_wen"}, 64'(bus.hi_wen), 64'(ehw));
        check_eq({tag, "_lo_wen"}, 64'(bus.lo_wen), 64'(elw));
        if (ehw) check_eq({tag, "_hi"}, 64'(bus.hi_data), 64'(ehi));
        if (elw) check_eq({tag, "_lo"}, 64'(bus.lo_data), 64'(elo));
        @(negedge clk);
        check_eq({tag, "_idle_after"}, {61'd0, bus.busy, bus.hi_wen, bus.lo_wen}, 64'd0);
    endtask

    initial begin
        int wen_seen;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        logic [31:0] edge_vals [4];
        edge_vals[0] = 32'h8000_0000; edge_vals[1] = 32'hFFFF_FFFF;
        edge_vals[2] = 32'h0000_0001; edge_vals[3] = 32'h7FFF_FFFF;

        rst = 1'b1; bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_ctrl", {61'd0, bus.busy, bus.hi_wen, bus.lo_wen}, 64'd0);
        check_eq("reset_data", {bus.hi_data, bus.lo_data}, 64'd0);
        rst = 1'b0;

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        run_op(3'd0, 32'hFFFF_FFFD, 32'd7,         1'b0, "mult_neg");
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2,         1'b0, "div_neg");
        run_op(3'd3, 32'd7,         32'd2,         1'b0, "divu");
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        run_op(3'd3, 32'd5,         32'd0,         1'b0, "divu_zero");
        run_op(3'd2, 32'hFFFF_FFF0, 32'd0,         1'b0, "div_zero_neg");
        run_op(3'd5, 32'h1234_5678, 32'd0,         1'b0, "mtlo");
        run_op(3'd4, 32'hCAFE_F00D, 32'd0,         1'b0, "mthi");
        run_op(3'd2, 32'd100,       32'hFFFF_FFF9, 1'b1, "div_disturbed");
        run_op(3'd6, 32'd1,         32'd1,         1'b0, "op6");

        // Reset in the 10th CALC cycle aborts without any write pulse.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd9; bus.b = 32'd9;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_abort_ctrl", {61'd0, bus.busy, bus.hi_wen, bus.lo_wen}, 64'd0);
        check_eq("rst_abort_data", {bus.hi_data, bus.lo_data}, 64'd0);
        rst = 1'b0;
        wen_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.hi_wen || bus.lo_wen || bus.busy) wen_seen++;
        end
        check_eq("rst_abort_no_wen", 64'(wen_seen), 64'd0);
        run_op(3'd1, 32'd3, 32'd4, 1'b0, "multu_after_rst");

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = 32'($urandom_range(0, 50)) - 32'd25; rb = 32'($urandom_range(1, 9)); end
                2: begin ra = $urandom; rb = 32'd0; end
                default: begin ra = edge_vals[$urandom_range(0, 3)]; rb = edge_vals[$urandom_range(0, 3)]; end
            endcase
            run_op(rop, ra, rb, 1'($urandom_range(0, 1)), $sformatf("rand%0d_op%0d", i, rop));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
